// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Requester (core, loader), memory-side and status signals of
//                the unified memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic [3:0]        core_wmask;
    logic [31:0]       core_rdata;
    logic              core_ack;
    logic              core_err;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [31:0]       ldr_wdata;
    logic [3:0]        ldr_wmask;
    logic [31:0]       ldr_rdata;
    logic              ldr_ack;
    logic              ldr_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_wmask,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_wmask,
        input  mem_rdata,
        output core_rdata, core_ack, core_err,
        output ldr_rdata, ldr_ack, ldr_err,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        output busy
    );

    // Requesters / memory side
    modport master (
        output core_req, core_we, core_addr, core_wdata, core_wmask,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_wmask,
        output mem_rdata,
        input  core_rdata, core_ack, core_err,
        input  ldr_rdata, ldr_ack, ldr_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter sharing a single-port 32-bit memory
//                between the core and the program loader, with ack/err
//                handshakes, configurable read latency and range/alignment
//                checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0]  C_WAIT_INIT = 3'(MEM_LATENCY - 1);
    localparam logic [31:0] C_MEM_WORDS = 32'(MEM_WORDS);

    state_t            state_q, state_d;
    logic              last_ldr_q, last_ldr_d;   // 1: loader was granted last
    logic              grant_ldr_q, grant_ldr_d; // owner of the current transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              w_pick_ldr;
    logic              w_bad;
    logic [31:0]       w_word;

    logic [31:0]       w_core_rdata, w_ldr_rdata;
    logic              w_core_ack, w_core_err, w_ldr_ack, w_ldr_err;
    logic              w_mem_en, w_mem_we;
    logic [ADDR_W-3:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;
    logic [3:0]        w_mem_wmask;

    // Tie goes to whoever was not granted last; a lone request always wins.
    assign w_pick_ldr = bus.ldr_req && (!bus.core_req || !last_ldr_q);

    // Reject misaligned or out-of-range latched addresses.
    assign w_word = 32'(addr_q[ADDR_W-1:2]);
    assign w_bad  = (addr_q[1:0] != 2'b00) || (w_word >= C_MEM_WORDS);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_ldr_q  <= 1'b1;
            grant_ldr_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ldr_q  <= last_ldr_d;
            grant_ldr_q <= grant_ldr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        last_ldr_d   = last_ldr_q;
        grant_ldr_d  = grant_ldr_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        w_core_rdata = '0;
        w_core_ack   = 1'b0;
        w_core_err   = 1'b0;
        w_ldr_rdata  = '0;
        w_ldr_ack    = 1'b0;
        w_ldr_err    = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_mem_wmask  = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.core_req || bus.ldr_req) begin
                    grant_ldr_d = w_pick_ldr;
                    last_ldr_d  = w_pick_ldr;
                    we_d        = w_pick_ldr ? bus.ldr_we    : bus.core_we;
                    addr_d      = w_pick_ldr ? bus.ldr_addr  : bus.core_addr;
                    wdata_d     = w_pick_ldr ? bus.ldr_wdata : bus.core_wdata;
                    wmask_d     = w_pick_ldr ? bus.ldr_wmask : bus.core_wmask;
                    rdata_d     = '0;   // writes and errors return zero
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (w_bad) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    w_mem_en    = 1'b1;
                    w_mem_we    = we_q;
                    w_mem_addr  = addr_q[ADDR_W-1:2];
                    w_mem_wdata = wdata_q;
                    w_mem_wmask = wmask_q;
                    if (we_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = C_WAIT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (grant_ldr_q) begin
                    w_ldr_ack   = 1'b1;
                    w_ldr_rdata = rdata_q;
                    w_ldr_err   = err_q;
                end else begin
                    w_core_ack   = 1'b1;
                    w_core_rdata = rdata_q;
                    w_core_err   = err_q;
                end
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.core_rdata = w_core_rdata;
    assign bus.core_ack   = w_core_ack;
    assign bus.core_err   = w_core_err;
    assign bus.ldr_rdata  = w_ldr_rdata;
    assign bus.ldr_ack    = w_ldr_ack;
    assign bus.ldr_err    = w_ldr_err;
    assign bus.mem_en     = w_mem_en;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.mem_wmask  = w_mem_wmask;
    assign bus.busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Two instances
//                (read latency 1 and 3) share a transaction-level model that
//                predicts grant order, ack cycles, memory strobes and data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 13;

    typedef struct packed {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [3:0]    wm;
    } req_t;

    typedef struct packed {
        logic c_ack, c_err, l_ack, l_err, en, we, busy;
        logic [31:0] c_rd, l_rd, wd;
        logic [AW-3:0] ma;
        logic [3:0] wm;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mem_init = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.ADDR_W(AW)) if1 ();
    mem_port_arbiter_if #(.ADDR_W(AW)) if3 ();

    mem_port_arbiter #(.ADDR_W(AW), .MEM_WORDS(1024), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1));
    mem_port_arbiter #(.ADDR_W(AW), .MEM_WORDS(1024), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(if3));

    always #5 clk = ~clk;

    // Memory models behind each arbiter, plus golden copies the bench updates.
    logic [31:0] mem  [2][1024];
    logic [31:0] gold [2][1024];
    logic        pv   [2][3];
    logic [31:0] pd   [2][3];
    logic [31:0] garb [2];
    bit          last_ldr [2];

    function automatic logic [31:0] initval(input int d, input int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B9) ^ ((d != 0) ? 32'h5A5A0000 : 32'h0000A5A5);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem[0][i] <= initval(0, i);
                mem[1][i] <= initval(1, i);
            end
        end else begin
            if (if1.mem_en && if1.mem_we && if1.mem_addr < 11'd1024)
                for (int b = 0; b < 4; b++)
                    if (if1.mem_wmask[b]) mem[0][if1.mem_addr[9:0]][8*b +: 8] <= if1.mem_wdata[8*b +: 8];
            if (if3.mem_en && if3.mem_we && if3.mem_addr < 11'd1024)
                for (int b = 0; b < 4; b++)
                    if (if3.mem_wmask[b]) mem[1][if3.mem_addr[9:0]][8*b +: 8] <= if3.mem_wdata[8*b +: 8];
        end
        pv[0][0] <= if1.mem_en && !if1.mem_we;
        pd[0][0] <= mem[0][if1.mem_addr[9:0]];
        pv[1][0] <= if3.mem_en && !if3.mem_we;
        pd[1][0] <= mem[1][if3.mem_addr[9:0]];
        pv[1][1] <= pv[1][0];
        pd[1][1] <= pd[1][0];
        pv[1][2] <= pv[1][1];
        pd[1][2] <= pd[1][1];
        garb[0]  <= $urandom;
        garb[1]  <= $urandom;
    end

    // Read data is only meaningful exactly latency cycles after the strobe.
    assign if1.mem_rdata = pv[0][0] ? pd[0][0] : garb[0];
    assign if3.mem_rdata = pv[1][2] ? pd[1][2] : garb[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit ldr, input req_t r);
        if (d == 0) begin
            if (ldr) begin
                if1.ldr_req = r.en; if1.ldr_we = r.we; if1.ldr_addr = r.addr;
                if1.ldr_wdata = r.wd; if1.ldr_wmask = r.wm;
            end else begin
                if1.core_req = r.en; if1.core_we = r.we; if1.core_addr = r.addr;
                if1.core_wdata = r.wd; if1.core_wmask = r.wm;
            end
        end else begin
            if (ldr) begin
                if3.ldr_req = r.en; if3.ldr_we = r.we; if3.ldr_addr = r.addr;
                if3.ldr_wdata = r.wd; if3.ldr_wmask = r.wm;
            end else begin
                if3.core_req = r.en; if3.core_we = r.we; if3.core_addr = r.addr;
                if3.core_wdata = r.wd; if3.core_wmask = r.wm;
            end
        end
    endtask

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o.c_ack = if1.core_ack; o.c_err = if1.core_err; o.c_rd = if1.core_rdata;
            o.l_ack = if1.ldr_ack;  o.l_err = if1.ldr_err;  o.l_rd = if1.ldr_rdata;
            o.en = if1.mem_en; o.we = if1.mem_we; o.ma = if1.mem_addr;
            o.wd = if1.mem_wdata; o.wm = if1.mem_wmask; o.busy = if1.busy;
        end else begin
            o.c_ack = if3.core_ack; o.c_err = if3.core_err; o.c_rd = if3.core_rdata;
            o.l_ack = if3.ldr_ack;  o.l_err = if3.ldr_err;  o.l_rd = if3.ldr_rdata;
            o.en = if3.mem_en; o.we = if3.mem_we; o.ma = if3.mem_addr;
            o.wd = if3.mem_wdata; o.wm = if3.mem_wmask; o.busy = if3.busy;
        end
        return o;
    endfunction

    function automatic req_t mk(input logic we, input logic [AW-1:0] a,
                                input logic [31:0] wd, input logic [3:0] wm);
        req_t r;
        r.en = 1'b1; r.we = we; r.addr = a; r.wd = wd; r.wm = wm;
        return r;
    endfunction

    function automatic req_t rand_req(input bit en);
        req_t r;
        int sel;
        sel    = $urandom_range(0, 19);
        r.en   = en;
        r.we   = 1'($urandom_range(0, 1));
        r.wd   = $urandom;
        r.wm   = 4'($urandom);
        if (sel < 15)      r.addr = {1'b0, 10'($urandom_range(0, 1023)), 2'b00};
        else if (sel < 17) r.addr = {1'b0, 10'($urandom), 2'($urandom_range(1, 3))};
        else               r.addr = {1'b1, 10'($urandom), 2'b00};
        if (!en) r = '0;
        return r;
    endfunction

    // Issue one request or a simultaneous pair (issued in cycle 0) on DUT d
    // and compare every response cycle against the transaction-level model.
    task automatic run(input int d, input req_t c, input req_t l);
        req_t        rq [2];
        string       nm [2];
        int          lat, n, first, r, ll, start, kend;
        bit          ok;
        int          exp_ack [2], got_ack [2];
        logic        exp_err [2], got_err [2];
        logic [31:0] exp_rd [2], got_rd [2];
        int          ne, ng, quiet;
        int          e_cyc [2], g_cyc [4];
        logic        e_we [2], g_we [4];
        logic [10:0] e_a [2], g_a [4];
        logic [31:0] e_wd [2], g_wd [4];
        logic [3:0]  e_wm [2], g_wm [4];
        obs_t        o;

        rq[0] = c; rq[1] = l; nm[0] = "core"; nm[1] = "ldr";
        lat   = (d == 0) ? 1 : 3;
        n     = int'(c.en) + int'(l.en);
        first = (l.en && (!c.en || !last_ldr[d])) ? 1 : 0;
        exp_ack[0] = -1; exp_ack[1] = -1; got_ack[0] = -1; got_ack[1] = -1;
        exp_err[0] = 0; exp_err[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
        got_err[0] = 0; got_err[1] = 0; got_rd[0] = 0; got_rd[1] = 0;
        ne = 0; ng = 0; quiet = 0; kend = 0;

        for (int i = 0; i < n; i++) begin
            r     = (i == 0) ? first : 1 - first;
            ok    = (rq[r].addr[1:0] == 2'b00) && (rq[r].addr[AW-1:2] < 11'd1024);
            ll    = (ok && !rq[r].we) ? lat : 0;
            start = (i == 0) ? 0 : exp_ack[first] + 1;
            exp_ack[r] = start + 2 + ll;
            exp_err[r] = !ok;
            exp_rd[r]  = (ok && !rq[r].we) ? gold[d][rq[r].addr[11:2]] : 32'h0;
            if (ok) begin
                e_cyc[ne] = start + 1; e_we[ne] = rq[r].we; e_a[ne] = rq[r].addr[AW-1:2];
                e_wd[ne] = rq[r].wd; e_wm[ne] = rq[r].wm; ne++;
                if (rq[r].we)
                    for (int b = 0; b < 4; b++)
                        if (rq[r].wm[b]) gold[d][rq[r].addr[11:2]][8*b +: 8] = rq[r].wd[8*b +: 8];
            end
            kend = exp_ack[r] + 2;
            last_ldr[d] = (r == 1);
        end

        drive(d, 0, c);
        drive(d, 1, l);
        for (int k = 0; k <= kend; k++) begin
            @(negedge clk);
            o = sample(d);
            if (k == 1) check($sformatf("busy_d%0d", d), 32'(o.busy), 32'd1);
            if (o.c_ack) begin
                if (got_ack[0] != -1) quiet++;
                else begin got_ack[0] = k; got_err[0] = o.c_err; got_rd[0] = o.c_rd; end
            end else if (o.c_err || o.c_rd != 0) quiet++;
            if (o.l_ack) begin
                if (got_ack[1] != -1) quiet++;
                else begin got_ack[1] = k; got_err[1] = o.l_err; got_rd[1] = o.l_rd; end
            end else if (o.l_err || o.l_rd != 0) quiet++;
            if (o.en) begin
                if (ng < 4) begin
                    g_cyc[ng] = k; g_we[ng] = o.we; g_a[ng] = o.ma; g_wd[ng] = o.wd; g_wm[ng] = o.wm;
                end
                ng++;
            end else if (o.we || o.ma != 0 || o.wd != 0 || o.wm != 0) quiet++;
            @(posedge clk);
            #1;
            if (got_ack[0] == k) drive(d, 0, '0);
            if (got_ack[1] == k) drive(d, 1, '0);
        end

        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ack_cycle_d%0d", nm[i], d), 32'(got_ack[i]), 32'(exp_ack[i]));
            if (exp_ack[i] >= 0) begin
                check($sformatf("%s_err_d%0d", nm[i], d), 32'(got_err[i]), 32'(exp_err[i]));
                check($sformatf("%s_rdata_d%0d", nm[i], d), got_rd[i], exp_rd[i]);
            end
        end
        check($sformatf("mem_en_count_d%0d", d), 32'(ng), 32'(ne));
        for (int i = 0; i < ne && i < ng; i++) begin
            check($sformatf("mem_en_cycle_d%0d", d), 32'(g_cyc[i]), 32'(e_cyc[i]));
            check($sformatf("mem_we_d%0d", d), 32'(g_we[i]), 32'(e_we[i]));
            check($sformatf("mem_addr_d%0d", d), 32'(g_a[i]), 32'(e_a[i]));
            check($sformatf("mem_wdata_d%0d", d), g_wd[i], e_wd[i]);
            check($sformatf("mem_wmask_d%0d", d), 32'(g_wm[i]), 32'(e_wm[i]));
        end
        check($sformatf("quiet_outputs_d%0d", d), 32'(quiet), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        for (int dd = 0; dd < 2; dd++) begin
            last_ldr[dd] = 1'b1;
            for (int i = 0; i < 1024; i++) gold[dd][i] = initval(dd, i);
            drive(dd, 0, '0);
            drive(dd, 1, '0);
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        for (int dd = 0; dd < 2; dd++) begin
            o = sample(dd);
            check($sformatf("rst_busy_d%0d", dd), 32'(o.busy), 32'd0);
            check($sformatf("rst_acks_d%0d", dd), 32'({o.c_ack, o.l_ack}), 32'd0);
            check($sformatf("rst_mem_en_d%0d", dd), 32'(o.en), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Tie-breaking after reset: core, loader, core.
        for (int t = 0; t < 3; t++)
            run(0, mk(1'b0, 13'h010, 32'h0, 4'hF), mk(1'b1, 13'(13'h100 + 4 * t), 32'hA5A50000 + 32'(t), 4'hF));

        // Core read of the preset word and loader partial write.
        run(0, mk(1'b0, 13'h010, 32'h0, 4'h0), '0);
        run(0, '0, mk(1'b1, 13'h020, 32'h12345678, 4'b0011));
        run(0, '0, mk(1'b0, 13'h020, 32'h0, 4'h0));
        // Zero-mask write still strobes memory.
        run(0, mk(1'b1, 13'h030, 32'hFFFFFFFF, 4'b0000), '0);

        // Misaligned and out-of-range accesses.
        run(0, mk(1'b0, 13'h002, 32'h0, 4'h0), '0);
        run(0, '0, mk(1'b1, 13'h1000, 32'hCAFEF00D, 4'hF));
        run(0, mk(1'b1, 13'h0FFC, 32'h11223344, 4'hF), mk(1'b0, 13'h0FFC, 32'h0, 4'h0));

        // Longer latency instance.
        run(1, mk(1'b0, 13'h010, 32'h0, 4'h0), '0);
        run(1, mk(1'b1, 13'h044, 32'h89ABCDEF, 4'b1100), mk(1'b0, 13'h044, 32'h0, 4'h0));

        // Reset while a read is waiting on memory.
        drive(1, 0, mk(1'b0, 13'h040, 32'h0, 4'h0));
        repeat (3) @(negedge clk);
        o = sample(1);
        check("mid_busy_before_reset", 32'(o.busy), 32'd1);
        reset = 1'b0;
        #1;
        o = sample(1);
        check("mid_rst_busy", 32'(o.busy), 32'd0);
        check("mid_rst_acks", 32'({o.c_ack, o.l_ack, o.c_err, o.en}), 32'd0);
        drive(1, 0, '0);
        repeat (3) begin
            @(negedge clk);
            o = sample(1);
            check("mid_rst_no_ack", 32'({o.c_ack, o.l_ack}), 32'd0);
        end
        reset = 1'b1;
        last_ldr[0] = 1'b1;
        last_ldr[1] = 1'b1;
        @(posedge clk);
        #1;
        run(1, mk(1'b0, 13'h040, 32'h0, 4'h0), mk(1'b1, 13'h048, 32'h55AA55AA, 4'hF));

        // Randomised traffic on both instances.
        for (int t = 0; t < 40; t++) begin
            int d, mode;
            d    = $urandom_range(0, 1);
            mode = $urandom_range(0, 2);
            run(d, rand_req(mode != 1), rand_req(mode != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the multi-cycle core's memory interface and the program loader port.
- The core raises a request in FETCH, MEM_READ and MEM_WRITE and stalls until it sees ack.
- The loader writes program images and reads them back for checking.
- Provides per-request ack/err handshakes, round-robin arbitration, a configurable memory read latency, and range/alignment checking.

Parameters:
- ADDR_W, 12, byte-address width of requester ports.
- MEM_WORDS, 1024, number of 32-bit words implemented; word addresses at or above this are out of range.
- MEM_LATENCY, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..7.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- core_req  in  1  core request; held with all core_* fields stable until core_ack.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  byte address.
- core_wdata  in  32  write data.
- core_wmask  in  4  byte-lane write enables.
- core_rdata  out  32  read data; valid only while core_ack=1, else 0.
- core_ack  out  1  one-cycle completion pulse.
- core_err  out  1  with core_ack: access rejected (misaligned or out of range).
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_wmask  in  1/1/ADDR_W/32/4  loader request; same rules as core_*.
- ldr_rdata, ldr_ack, ldr_err  out  32/1/1  loader response; same rules as core_*.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W-2  word address (byte address >> 2).
- mem_wdata  out  32  write data.
- mem_wmask  out  4  byte-lane mask.
- mem_rdata  in  32  read data, valid MEM_LATENCY cycles after the mem_en cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=LDR, wait counter=0, captured data=0.
  - All outputs 0; any in-flight transaction is discarded with no ack; requesters reissue after reset.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the requester that is not last_grant (core wins the first tie after reset).
  - On grant: latch winner's we/addr/wdata/wmask, update last_grant, go to ACCESS.
- ACCESS:
  - If latched addr[1:0]!=0 or (addr>>2)>=MEM_WORDS: mem_en stays 0, set err flag, go to DONE.
  - Otherwise assert mem_en=1 with mem_we/mem_addr/mem_wdata/mem_wmask from the latch.
  - Write: go to DONE.
  - Read: load counter with MEM_LATENCY-1, go to WAIT.
- WAIT:
  - counter!=0: decrement and stay in WAIT.
  - counter==0: capture mem_rdata, go to DONE.
- DONE:
  - Pulse the winner's ack for exactly one cycle; drive its rdata from the capture register (0 for writes and errors) and err from the flag.
  - The other requester's outputs stay 0. Clear err flag, go to IDLE.
- mem_* outputs are 0 whenever mem_en=0.
- Latency, request sampled in IDLE at cycle c:
  - Write ack at c+2.
  - Read ack at c+2+MEM_LATENCY.
  - Error ack at c+2.
- The IDLE cycle after DONE always exists, so a requester reissuing on the edge after its ack is sampled normally.
- Requests asserted while busy wait in the IDLE decision; no request is ever dropped.
- A requester that deasserts req before ack is a protocol violation; the arbiter completes the latched transaction regardless.
- A loser is always granted next, so maximum wait is one foreign transaction.
- mem_wmask is passed through unchanged; all-zero masks on writes are legal and still pulse mem_en.

Test Plan:
- Core read, MEM_LATENCY=1: core_req at addr 0x010, mem_rdata=0xDEADBEEF on the cycle after mem_en -> mem_addr=0x004, core_ack at c+3 with core_rdata=0xDEADBEEF, ldr outputs 0.
- Loader write: addr 0x020, wdata 0x12345678, wmask 4'b0011 -> single-cycle mem_en=1, mem_we=1, mem_addr=0x008, mem_wmask=0011, ldr_ack at c+2, ldr_err=0.
- Contention after reset: both req simultaneously, repeated three times -> grant order core, ldr, core; each loser's ack arrives immediately after the winner's transaction.
- Errors: core read at addr 0x002 -> core_ack with core_err=1, core_rdata=0, mem_en never asserted; ldr write at 0x1000 (word 1024) -> ldr_err=1, no mem_en.
- MEM_LATENCY=3 read: ack exactly at c+5; mem_rdata toggling before the capture cycle must not appear in core_rdata.
- Reset mid-operation: drop reset to 0 during WAIT -> outputs 0 immediately, no ack; release, reissue -> normal completion, core wins the tie.
